uart_alu_ctrl: RTL and testbench
================================

Name: uart_alu_ctrl

Overview:
- Sequencer between the UART block (RX/TX FIFOs) and a combinational ALU.
- Pops three bytes from the RX FIFO in order: operand A, operand B, opcode. Presents them to the ALU as held registers.
- Samples the ALU result and pushes it into the TX FIFO once TX has room, then waits for the next frame.
- One instance per UART/ALU pair in the top level.

Parameters:
- NB_UARTALUCTRL_DATA, 8, data byte / operand / result width.
- NB_UARTALUCTRL_OP, 6, opcode width; taken from the low bits of the third byte.
- TIMEOUT_CYCLES, 2500000, inter-byte timeout in clocks (50 ms at 50 MHz). Used only with the optional feature.
- NB_UARTALUCTRL_TIMER, 24, timeout counter width; must satisfy 2^NB_UARTALUCTRL_TIMER > TIMEOUT_CYCLES.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  synchronous, active-low reset.
- i_uartalucntrl_fiforx_EMPTY  in  1  RX FIFO empty.
- i_uartalucntrl_fiforx_READDATA  in  NB_DATA  RX FIFO head; valid while not empty.
- o_uartalucntrl_fiforx_READ  out  1  RX FIFO pop strobe, one cycle.
- i_uartalucntrl_fifotx_FULL  in  1  TX FIFO full.
- o_uartalucntrl_fifotx_WRITE  out  1  TX FIFO push strobe, one cycle.
- o_uartalucntrl_fifotx_WRITEDATA  out  NB_DATA  result byte.
- o_uartalucntrl_alu_A  out  NB_DATA  operand A register.
- o_uartalucntrl_alu_B  out  NB_DATA  operand B register.
- o_uartalucntrl_alu_OP  out  NB_OP  opcode register.
- i_uartalucntrl_alu_RESULT  in  NB_DATA  combinational ALU result.
- o_uartalucntrl_DONE  out  1  frame-complete pulse.
- o_uartalucntrl_TIMEOUT  out  1  frame-abort pulse; constant 0 without the macro.

Behaviour:
- Reset (i_reset==0 at a clk edge):
  - State goes to WAIT_A.
  - All outputs, the A/B/OP registers, the result register and the timer clear to 0.
  - A reset mid-frame discards the partial frame; bytes already popped are lost.
- States: WAIT_A, POP_A, WAIT_B, POP_B, WAIT_OP, POP_OP, EXEC, SEND, WRITE.
- WAIT_x (x = A, B, OP):
  - If EMPTY==0: latch READDATA into the x register and go to POP_x.
  - For OP, latch only READDATA[NB_OP-1:0].
  - Otherwise stay.
- POP_x:
  - fiforx_READ=1 for exactly this cycle (Moore decode). FIFO pops at the end of the cycle.
  - Next state: POP_A→WAIT_B, POP_B→WAIT_OP, POP_OP→EXEC.
  - This costs one cycle per byte, so the WAIT states always see an updated EMPTY. The controller never double-pops.
- EXEC:
  - The ALU has had one full cycle with stable A/B/OP.
  - Register the ALU result into the result register, then go to SEND.
- SEND:
  - If FULL==0, go to WRITE; otherwise stay.
  - While stalled, A/B/OP and the result hold, and RX is not read.
- WRITE:
  - fifotx_WRITE=1 and DONE=1 for exactly this cycle; WRITEDATA = result register.
  - Next state: WAIT_A.
- Latency: third byte visible at RX head → TX write strobe = 4 cycles (WAIT_OP, POP_OP, EXEC, SEND, with the write in the 5th cycle), when TX is not full.
- Minimum frame time: 9 cycles with all bytes available back to back.
- A/B/OP registers hold their values after the frame until overwritten. WRITEDATA holds the last result.
- READ and WRITE are never asserted in the same cycle.
- Other strobes are 0 outside their states.
- EMPTY and FULL are sampled only in the WAIT and SEND states respectively.

Optional Feature:
- Macro: UARTALUCTRL_TIMEOUT_EN.
- With the macro defined:
  - The timer clears on entry to WAIT_B or WAIT_OP.
  - It increments each cycle spent in those states with EMPTY==1.
  - When it reaches TIMEOUT_CYCLES-1 and EMPTY is still 1: go to WAIT_A, pulse o_uartalucntrl_TIMEOUT for one cycle, and clear the timer.
  - A/B/OP keep their last values.
  - A byte arriving in the same cycle as expiry wins: it is accepted and there is no timeout.
  - WAIT_A and SEND never time out.
- Without the macro: no timer logic; TIMEOUT is tied 0; partial frames wait indefinitely.

Test Plan:
- Reset → all outputs 0, state WAIT_A. Bench ALU model uses OP 6'h20 = add, 6'h22 = sub.
- Push 0x05, 0x03, 0x20 → three single-cycle READ pulses; A=0x05, B=0x03, OP=0x20; one WRITE with data 0x08; DONE coincident with WRITE.
- Push 0x05, 0x07, 0xE2 → OP=0x22 (top bits dropped); WRITE data 0xFE (wrap-around).
- Hold FULL=1, complete a frame → no WRITE and no further READ while stalled (extra RX bytes stay queued). Release FULL → WRITE exactly once, 2 cycles later, then the next frame is processed.
- Push 0x10, then assert reset for one cycle, then push 0x01, 0x02, 0x20 → result 0x03 (0x10 discarded).
- With UARTALUCTRL_TIMEOUT_EN and TIMEOUT_CYCLES=100: push one byte and wait → TIMEOUT pulse after 100 cycles in WAIT_B, no WRITE. Then a full frame 0x02, 0x02, 0x20 → 0x04.

Source files
------------

// File: rtl/uart_alu_ctrl_if.sv
// Bus between uart_alu_ctrl, the UART RX/TX FIFOs and the ALU.
// master = controller side, slave = FIFO/ALU side.
interface uart_alu_ctrl_if #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
);
  logic               i_uartalucntrl_fiforx_EMPTY;
  logic [NB_DATA-1:0] i_uartalucntrl_fiforx_READDATA;
  logic               o_uartalucntrl_fiforx_READ;
  logic               i_uartalucntrl_fifotx_FULL;
  logic               o_uartalucntrl_fifotx_WRITE;
  logic [NB_DATA-1:0] o_uartalucntrl_fifotx_WRITEDATA;
  logic [NB_DATA-1:0] o_uartalucntrl_alu_A;
  logic [NB_DATA-1:0] o_uartalucntrl_alu_B;
  logic [NB_OP-1:0]   o_uartalucntrl_alu_OP;
  logic [NB_DATA-1:0] i_uartalucntrl_alu_RESULT;
  logic               o_uartalucntrl_DONE;
  logic               o_uartalucntrl_TIMEOUT;

  modport master (
    input  i_uartalucntrl_fiforx_EMPTY,
    input  i_uartalucntrl_fiforx_READDATA,
    output o_uartalucntrl_fiforx_READ,
    input  i_uartalucntrl_fifotx_FULL,
    output o_uartalucntrl_fifotx_WRITE,
    output o_uartalucntrl_fifotx_WRITEDATA,
    output o_uartalucntrl_alu_A,
    output o_uartalucntrl_alu_B,
    output o_uartalucntrl_alu_OP,
    input  i_uartalucntrl_alu_RESULT,
    output o_uartalucntrl_DONE,
    output o_uartalucntrl_TIMEOUT
  );

  modport slave (
    output i_uartalucntrl_fiforx_EMPTY,
    output i_uartalucntrl_fiforx_READDATA,
    input  o_uartalucntrl_fiforx_READ,
    output i_uartalucntrl_fifotx_FULL,
    input  o_uartalucntrl_fifotx_WRITE,
    input  o_uartalucntrl_fifotx_WRITEDATA,
    input  o_uartalucntrl_alu_A,
    input  o_uartalucntrl_alu_B,
    input  o_uartalucntrl_alu_OP,
    output i_uartalucntrl_alu_RESULT,
    input  o_uartalucntrl_DONE,
    input  o_uartalucntrl_TIMEOUT
  );
endinterface

// File: rtl/uart_alu_ctrl.sv
// UART <-> ALU sequencer: pops A, B, OP from RX, pushes result to TX.
// Optional inter-byte timeout: define UARTALUCTRL_TIMEOUT_EN.
module uart_alu_ctrl #(
  parameter int NB_UARTALUCTRL_DATA  = 8,
  parameter int NB_UARTALUCTRL_OP    = 6,
  parameter int TIMEOUT_CYCLES       = 2500000,
  parameter int NB_UARTALUCTRL_TIMER = 24
) (
  input  logic            i_clk,
  input  logic            i_reset,
  uart_alu_ctrl_if.master bus
);
  localparam int NB_D = NB_UARTALUCTRL_DATA;
  localparam int NB_O = NB_UARTALUCTRL_OP;
  localparam int NB_T = NB_UARTALUCTRL_TIMER;

  if ((64'd1 << NB_T) <= 64'(TIMEOUT_CYCLES))
  begin : g_timer_width_bad
    $error("NB_UARTALUCTRL_TIMER too narrow");
  end

  if (NB_O > NB_D) begin : g_op_width_bad
    $error("opcode wider than data byte");
  end

  typedef enum logic [3:0] {
    WAIT_A,
    POP_A,
    WAIT_B,
    POP_B,
    WAIT_OP,
    POP_OP,
    EXEC,
    SEND,
    WRITE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [NB_D-1:0] a_q;
  logic [NB_D-1:0] b_q;
  logic [NB_O-1:0] op_q;
  logic [NB_D-1:0] res_q;
  logic            rx_avail;
  logic            tx_room;
  logic            expire;
  logic            rd;
  logic            wr;

  assign rx_avail = ~bus.i_uartalucntrl_fiforx_EMPTY;
  assign tx_room  = ~bus.i_uartalucntrl_fifotx_FULL;

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state <= WAIT_A;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and Moore strobes
  always_comb begin
    state_nxt = state;
    rd        = 1'b0;
    wr        = 1'b0;
    unique case (state)
      WAIT_A: begin
        if (rx_avail) state_nxt = POP_A;
      end
      POP_A: begin
        rd        = 1'b1;
        state_nxt = WAIT_B;
      end
      WAIT_B: begin
        if (rx_avail)    state_nxt = POP_B;
        else if (expire) state_nxt = WAIT_A;
      end
      POP_B: begin
        rd        = 1'b1;
        state_nxt = WAIT_OP;
      end
      WAIT_OP: begin
        if (rx_avail)    state_nxt = POP_OP;
        else if (expire) state_nxt = WAIT_A;
      end
      POP_OP: begin
        rd        = 1'b1;
        state_nxt = EXEC;
      end
      EXEC: begin
        state_nxt = SEND;
      end
      SEND: begin
        if (tx_room) state_nxt = WRITE;
      end
      WRITE: begin
        wr        = 1'b1;
        state_nxt = WAIT_A;
      end
      default: begin
        state_nxt = WAIT_A;
      end
    endcase
  end

  // Operand capture while the byte sits at the RX head;
  // result capture after the ALU had a full stable cycle
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      res_q <= '0;
    end else begin
      if (state == WAIT_A && rx_avail) begin
        a_q <= bus.i_uartalucntrl_fiforx_READDATA;
      end
      if (state == WAIT_B && rx_avail) begin
        b_q <= bus.i_uartalucntrl_fiforx_READDATA;
      end
      if (state == WAIT_OP && rx_avail) begin
        op_q <= bus.i_uartalucntrl_fiforx_READDATA[NB_O-1:0];
      end
      if (state == EXEC) begin
        res_q <= bus.i_uartalucntrl_alu_RESULT;
      end
    end
  end

`ifdef UARTALUCTRL_TIMEOUT_EN
  localparam logic [NB_T-1:0] TO_LAST =
    NB_T'(TIMEOUT_CYCLES - 1);

  logic [NB_T-1:0] timer_q;
  logic            timeout_q;
  logic            in_mid;

  assign in_mid = (state == WAIT_B) || (state == WAIT_OP);
  assign expire = in_mid && !rx_avail && (timer_q == TO_LAST);

  // Inter-byte timer; idle at zero outside WAIT_B/WAIT_OP
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= expire;
      if (!in_mid || expire) begin
        timer_q <= '0;
      end else if (!rx_avail) begin
        timer_q <= timer_q + 1'b1;
      end
    end
  end

  assign bus.o_uartalucntrl_TIMEOUT = timeout_q;
`else
  assign expire                     = 1'b0;
  assign bus.o_uartalucntrl_TIMEOUT = 1'b0;
`endif

  assign bus.o_uartalucntrl_fiforx_READ      = rd;
  assign bus.o_uartalucntrl_fifotx_WRITE     = wr;
  assign bus.o_uartalucntrl_DONE             = wr;
  assign bus.o_uartalucntrl_fifotx_WRITEDATA = res_q;
  assign bus.o_uartalucntrl_alu_A            = a_q;
  assign bus.o_uartalucntrl_alu_B            = b_q;
  assign bus.o_uartalucntrl_alu_OP           = op_q;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Randomized bench for uart_alu_ctrl with FIFO/ALU models.
// Frame-level reference model plus directed literal checks.
module tb_uart_alu_ctrl;
  localparam int NBD = 8;
  localparam int NBO = 6;
  localparam int TO  = 100;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_alu_ctrl_if #(.NB_DATA(NBD), .NB_OP(NBO)) bus();

  uart_alu_ctrl #(
    .NB_UARTALUCTRL_DATA (NBD),
    .NB_UARTALUCTRL_OP   (NBO),
    .TIMEOUT_CYCLES      (TO),
    .NB_UARTALUCTRL_TIMER(24)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    logic [7:0] r;
  } frame_t;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] rxq[$];
  logic [7:0] pend[$];
  logic [7:0] grp[$];
  frame_t     expq[$];
  int         n_read  = 0;
  int         n_write = 0;
  int         n_to    = 0;
  logic       rst_at_edge  = 1'b0;
  logic       full_at_edge = 1'b0;
  logic       prev_read    = 1'b0;

  function automatic logic [7:0] alu(input logic [7:0] a,
                                     input logic [7:0] b,
                                     input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      default: return 8'h00;
    endcase
  endfunction

  assign bus.i_uartalucntrl_alu_RESULT =
    alu(bus.o_uartalucntrl_alu_A,
        bus.o_uartalucntrl_alu_B,
        bus.o_uartalucntrl_alu_OP);

  function automatic void chk(input string nm,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  function automatic void fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got expired bound want event", nm);
  endfunction

  always @(posedge clk) begin
    rst_at_edge  <= rst_n;
    full_at_edge <= bus.i_uartalucntrl_fifotx_FULL;
  end

  // Compare process plus RX FIFO model (pops at end of READ cycle)
  initial begin
    frame_t f;
    logic rd;
    logic wr;
    bus.i_uartalucntrl_fiforx_EMPTY    = 1'b1;
    bus.i_uartalucntrl_fiforx_READDATA = '0;
    forever begin
      @(negedge clk);
      rd = bus.o_uartalucntrl_fiforx_READ;
      wr = bus.o_uartalucntrl_fifotx_WRITE;
      if (!rst_at_edge) begin
        grp.delete();
        expq.delete();
        prev_read = 1'b0;
      end else begin
        chk("rd_wr_excl", {31'd0, rd & wr}, 32'd0);
        chk("done_eq_wr", {31'd0, bus.o_uartalucntrl_DONE},
            {31'd0, wr});
        if (rd) begin
          chk("rd_nonempty", {31'd0, rxq.size() > 0}, 32'd1);
          chk("rd_single", {31'd0, prev_read}, 32'd0);
          n_read++;
          if (rxq.size() > 0) grp.push_back(rxq[0]);
          if (grp.size() == 3) begin
            f.a  = grp[0];
            f.b  = grp[1];
            f.op = grp[2][5:0];
            f.r  = alu(f.a, f.b, f.op);
            expq.push_back(f);
            grp.delete();
          end
        end
        if (wr) begin
          n_write++;
          chk("wr_tx_room", {31'd0, full_at_edge}, 32'd0);
          if (expq.size() == 0) begin
            chk("wr_unexpected", 32'd1, 32'd0);
          end else begin
            f = expq.pop_front();
            chk("wr_data", {24'd0, bus.o_uartalucntrl_fifotx_WRITEDATA},
                {24'd0, f.r});
            chk("wr_a", {24'd0, bus.o_uartalucntrl_alu_A}, {24'd0, f.a});
            chk("wr_b", {24'd0, bus.o_uartalucntrl_alu_B}, {24'd0, f.b});
            chk("wr_op", {26'd0, bus.o_uartalucntrl_alu_OP}, {26'd0, f.op});
          end
        end
`ifdef UARTALUCTRL_TIMEOUT_EN
        if (bus.o_uartalucntrl_TIMEOUT) begin
          n_to++;
          grp.delete();
        end
`else
        chk("timeout_low", {31'd0, bus.o_uartalucntrl_TIMEOUT}, 32'd0);
`endif
        prev_read = rd;
      end
      if (rd && rxq.size() > 0) void'(rxq.pop_front());
      while (pend.size() > 0) rxq.push_back(pend.pop_front());
      bus.i_uartalucntrl_fiforx_EMPTY = (rxq.size() == 0);
      bus.i_uartalucntrl_fiforx_READDATA =
        (rxq.size() > 0) ? rxq[0] : 8'h00;
    end
  end

  task automatic push3(input logic [7:0] a,
                       input logic [7:0] b,
                       input logic [7:0] o);
    @(posedge clk);
    #1;
    pend.push_back(a);
    pend.push_back(b);
    pend.push_back(o);
  endtask

  task automatic wait_write(input int lim, output int k);
    k = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      k++;
      if (bus.o_uartalucntrl_fifotx_WRITE) return;
    end
    fail("write_wait");
    k = -1;
  endtask

  initial begin
    int k;
    int r0;
    int w0;
    logic [7:0] ops[6];
    logic [7:0] by;
    ops[0] = 8'h20; ops[1] = 8'h22; ops[2] = 8'h24;
    ops[3] = 8'h25; ops[4] = 8'h26; ops[5] = 8'h3f;
    bus.i_uartalucntrl_fifotx_FULL = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_read", {31'd0, bus.o_uartalucntrl_fiforx_READ}, 32'd0);
    chk("rst_write", {31'd0, bus.o_uartalucntrl_fifotx_WRITE}, 32'd0);
    chk("rst_done", {31'd0, bus.o_uartalucntrl_DONE}, 32'd0);
    chk("rst_tout", {31'd0, bus.o_uartalucntrl_TIMEOUT}, 32'd0);
    chk("rst_wdata", {24'd0, bus.o_uartalucntrl_fifotx_WRITEDATA}, 32'd0);
    chk("rst_a", {24'd0, bus.o_uartalucntrl_alu_A}, 32'd0);
    chk("rst_b", {24'd0, bus.o_uartalucntrl_alu_B}, 32'd0);
    chk("rst_op", {26'd0, bus.o_uartalucntrl_alu_OP}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // add: 5 + 3, back-to-back frame time
    r0 = n_read;
    push3(8'h05, 8'h03, 8'h20);
    wait_write(50, k);
    chk("t1_frame_cycles", k, 9);
    chk("t1_data", {24'd0, bus.o_uartalucntrl_fifotx_WRITEDATA}, 32'h08);
    chk("t1_done", {31'd0, bus.o_uartalucntrl_DONE}, 32'd1);
    chk("t1_a", {24'd0, bus.o_uartalucntrl_alu_A}, 32'h05);
    chk("t1_b", {24'd0, bus.o_uartalucntrl_alu_B}, 32'h03);
    chk("t1_op", {26'd0, bus.o_uartalucntrl_alu_OP}, 32'h20);
    chk("t1_reads", n_read - r0, 3);

    // sub with dropped opcode bits: 5 - 7 wraps
    push3(8'h05, 8'h07, 8'hE2);
    wait_write(50, k);
    chk("t2_frame_cycles", k, 9);
    chk("t2_data", {24'd0, bus.o_uartalucntrl_fifotx_WRITEDATA}, 32'hFE);
    chk("t2_op", {26'd0, bus.o_uartalucntrl_alu_OP}, 32'h22);
    @(negedge clk);
    chk("t2_wdata_hold", {24'd0, bus.o_uartalucntrl_fifotx_WRITEDATA},
        32'hFE);

    // TX full stall, extra frame stays queued
    @(posedge clk);
    #1 bus.i_uartalucntrl_fifotx_FULL = 1'b1;
    r0 = n_read;
    w0 = n_write;
    push3(8'h30, 8'h11, 8'h22);
    push3(8'h04, 8'h05, 8'h20);
    repeat (30) @(posedge clk);
    #1;
    chk("t3_no_write", n_write - w0, 0);
    chk("t3_reads", n_read - r0, 3);
    chk("t3_queued", rxq.size(), 3);
    bus.i_uartalucntrl_fifotx_FULL = 1'b0;
    wait_write(20, k);
    chk("t3_release_lat", k, 2);
    chk("t3_data", {24'd0, bus.o_uartalucntrl_fifotx_WRITEDATA}, 32'h1F);
    wait_write(50, k);
    chk("t3_next_data", {24'd0, bus.o_uartalucntrl_fifotx_WRITEDATA},
        32'h09);
    chk("t3_writes", n_write - w0, 2);

    // reset mid-frame drops the popped byte
    @(posedge clk);
    #1 pend.push_back(8'h10);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    push3(8'h01, 8'h02, 8'h20);
    wait_write(50, k);
    chk("t4_data", {24'd0, bus.o_uartalucntrl_fifotx_WRITEDATA}, 32'h03);
    chk("t4_a", {24'd0, bus.o_uartalucntrl_alu_A}, 32'h01);

`ifdef UARTALUCTRL_TIMEOUT_EN
    // lone byte times out after TO cycles in WAIT_B
    w0 = n_write;
    @(posedge clk);
    #1 pend.push_back(8'hAA);
    k = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      k++;
      if (bus.o_uartalucntrl_TIMEOUT) break;
    end
    chk("t5_timeout_cycles", k, TO + 2);
    chk("t5_no_write", n_write - w0, 0);
    push3(8'h02, 8'h02, 8'h20);
    wait_write(50, k);
    chk("t5_data", {24'd0, bus.o_uartalucntrl_fifotx_WRITEDATA}, 32'h04);
`endif

    // randomized frames with random gaps and TX stalls
    w0 = n_write;
    for (int f = 0; f < 40; f++) begin
      for (int j = 0; j < 3; j++) begin
        if (j == 2) begin
          by = ops[$urandom_range(0, 5)];
          by[7:6] = 2'($urandom_range(0, 3));
        end else begin
          by = 8'($urandom);
        end
        @(posedge clk);
        #1;
        bus.i_uartalucntrl_fifotx_FULL = ($urandom_range(0, 3) == 0);
        pend.push_back(by);
        repeat ($urandom_range(0, 3)) @(posedge clk);
      end
    end
    @(posedge clk);
    #1 bus.i_uartalucntrl_fifotx_FULL = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (n_write - w0 >= 40) break;
    end
    repeat (3) @(negedge clk);
    chk("rand_writes", n_write - w0, 40);
    chk("rand_rx_drained", rxq.size(), 0);
    chk("rand_exp_drained", expq.size(), 0);
    chk("rand_no_timeout", n_to, 0 + (n_to > 0 ? 0 : 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got stuck want finish");
    $fatal(1);
  end
endmodule
